// File: rtl/enemy_queue_reader.sv
// Enemy spawn queue reader: walks the selected level's {ts,type} queue ROM and hands
// each entry to the enemy-instance allocator once the frame clock reaches its timestamp.
module enemy_queue_reader #(
   parameter int              ADDR_W = 6,
   parameter int              TS_W   = 12,
   parameter int              TYPE_W = 3,
   parameter logic [TS_W-1:0] END_TS = 12'hFFF
) (
   input  logic                     clk_25MHz,
   input  logic                     rst,
   input  logic                     frame_tick,
   input  logic                     start,
   input  logic [1:0]               level,
   input  logic                     halt,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [TS_W+TYPE_W-1:0]   rom_data1,
   input  logic [TS_W+TYPE_W-1:0]   rom_data2,
   input  logic [TS_W+TYPE_W-1:0]   rom_data3,
   output logic                     spawn_valid,
   output logic [TYPE_W-1:0]        spawn_type,
   input  logic                     spawn_ready,
   output logic [TS_W-1:0]          game_time,
   output logic [ADDR_W:0]          spawn_cnt,
   output logic                     queue_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_OFFER = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [TS_W-1:0]   GT_MAX    = END_TS - {{(TS_W-1){1'b0}}, 1'b1};

   logic [2:0]             state_q,      state_d;
   logic [1:0]             level_q,      level_d;
   logic [ADDR_W-1:0]      rom_addr_q,   rom_addr_d;
   logic [TS_W-1:0]        cur_ts_q,     cur_ts_d;
   logic [TYPE_W-1:0]      cur_type_q,   cur_type_d;
   logic [TS_W-1:0]        game_time_q,  game_time_d;
   logic [ADDR_W:0]        spawn_cnt_q,  spawn_cnt_d;
   logic                   queue_done_q, queue_done_d;

   logic [TS_W+TYPE_W-1:0] rom_sel;
   logic [TS_W-1:0]        sel_ts;
   logic [TYPE_W-1:0]      sel_type;
   logic                   restart;

   // halt outranks start, so a start arriving with halt is dropped.
   assign restart = start && (level != 2'd0) && !halt;

   always_comb begin
      rom_sel = '0;
      case (level_q)
         2'd1:    rom_sel = rom_data1;
         2'd2:    rom_sel = rom_data2;
         2'd3:    rom_sel = rom_data3;
         default: rom_sel = '0;
      endcase
   end

   assign {sel_ts, sel_type} = rom_sel;

   always_comb begin
      // NOTE: every _d starts from its _q so no path leaves a signal unassigned, which would infer a latch.
      state_d      = state_q;
      level_d      = level_q;
      rom_addr_d   = rom_addr_q;
      cur_ts_d     = cur_ts_q;
      cur_type_d   = cur_type_q;
      game_time_d  = game_time_q;
      spawn_cnt_d  = spawn_cnt_q;
      queue_done_d = queue_done_q;

      if (halt) begin
         state_d = S_IDLE;
      end else if (restart) begin
         state_d      = S_FETCH;
         level_d      = level;
         rom_addr_d   = '0;
         game_time_d  = '0;
         spawn_cnt_d  = '0;
         queue_done_d = 1'b0;
      end else begin
         if (frame_tick && (state_q != S_IDLE) && (game_time_q < GT_MAX))
            game_time_d = game_time_q + 1'b1;

         case (state_q)
            S_IDLE, S_DONE: state_d = state_q;
            S_FETCH:        state_d = S_LOAD;
            S_LOAD: begin
               cur_ts_d   = sel_ts;
               cur_type_d = sel_type;
               if (sel_ts == END_TS) begin
                  state_d      = S_DONE;
                  queue_done_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (game_time_q >= cur_ts_q)
                  state_d = S_OFFER;
            end
            S_OFFER: begin
               if (spawn_ready) begin
                  spawn_cnt_d = spawn_cnt_q + 1'b1;
                  // The last ROM slot ends the queue without wrapping the address.
                  if (rom_addr_q == LAST_ADDR) begin
                     state_d      = S_DONE;
                     queue_done_d = 1'b1;
                  end else begin
                     rom_addr_d = rom_addr_q + 1'b1;
                     state_d    = S_FETCH;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         state_q      <= S_IDLE;
         level_q      <= 2'd0;
         rom_addr_q   <= '0;
         cur_ts_q     <= '0;
         cur_type_q   <= '0;
         game_time_q  <= '0;
         spawn_cnt_q  <= '0;
         queue_done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register update from pre-edge values.
         state_q      <= state_d;
         level_q      <= level_d;
         rom_addr_q   <= rom_addr_d;
         cur_ts_q     <= cur_ts_d;
         cur_type_q   <= cur_type_d;
         game_time_q  <= game_time_d;
         spawn_cnt_q  <= spawn_cnt_d;
         queue_done_q <= queue_done_d;
      end
   end

   // cur_type only changes in LOAD, so the offered type is stable while valid is high.
   assign spawn_valid = (state_q == S_OFFER);
   assign spawn_type  = cur_type_q;
   assign rom_addr    = rom_addr_q;
   assign game_time   = game_time_q;
   assign spawn_cnt   = spawn_cnt_q;
   assign queue_done  = queue_done_q;

endmodule

// File: doc/enemy_queue_reader.md
Name: enemy_queue_reader

Overview:
- Reads the per-level enemy spawn queues, whose entries are {timestamp[12b], type[3b]}, one entry at a time.
- Keeps a frame-based game clock and compares each entry's timestamp against it.
- When an entry is due, issues a spawn request to the Game_Engine enemy-instance allocator over a valid/ready handshake.
- Sits between the three queue ROMs and the enemy slot allocator. It is the consumer of the queue data the level tables produce.

Parameters:
- ADDR_W, 6, queue ROM address width; queue depth = 2^ADDR_W entries.
- TS_W, 12, timestamp and game_time width, in frames.
- TYPE_W, 3, enemy type width.
- END_TS, 12'hFFF, timestamp value that marks end-of-queue.

Ports:
- clk_25MHz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame, synchronous to clk_25MHz.
- start  in  1  one-cycle pulse that starts a level (driven by gameInit_OP).
- level  in  2  queue select, latched on start: 1, 2 or 3. 0 means no level.
- halt  in  1  game over (game_win or game_lose); aborts reading.
- rom_addr  out  ADDR_W  shared read address to all three queue ROMs.
- rom_data1/2/3  in  TS_W+TYPE_W each  ROM outputs, {ts, type}, valid 1 cycle after rom_addr.
- spawn_valid  out  1  spawn request pending.
- spawn_type  out  TYPE_W  enemy type of the pending request.
- spawn_ready  in  1  allocator accepts the request; transfer occurs when valid && ready.
- game_time  out  TS_W  frames elapsed since start.
- spawn_cnt  out  ADDR_W+1  number of entries accepted by the allocator.
- queue_done  out  1  end marker reached or queue exhausted.

Behaviour:
- Reset values: rom_addr=0, spawn_valid=0, spawn_type=0, game_time=0, spawn_cnt=0, queue_done=0. FSM enters IDLE.
- FSM states: IDLE, FETCH, LOAD, WAIT_T, OFFER, DONE.
- IDLE:
  - start with level∈{1,2,3}: latch level; clear game_time, spawn_cnt, rom_addr; go to FETCH.
  - start with level=0: ignored.
- FETCH: rom_addr is stable for one cycle; go to LOAD.
- LOAD:
  - Capture the selected rom_dataN into the cur_ts/cur_type registers.
  - If the captured ts==END_TS, go to DONE.
  - Otherwise go to WAIT_T.
- WAIT_T: when game_time >= cur_ts, go to OFFER. spawn_valid is asserted on the next cycle, with spawn_type=cur_type.
- OFFER:
  - Hold spawn_valid and spawn_type stable until spawn_ready. Values must not change while valid is high.
  - On the transfer cycle: spawn_cnt+1; spawn_valid drops the next cycle.
  - If rom_addr == 2^ADDR_W-1, go to DONE. Otherwise rom_addr+1 and go to FETCH.
- Throughput: minimum 4 cycles per entry (FETCH, LOAD, WAIT_T, OFFER with ready already high). Entries with equal timestamps are issued back-to-back at this rate.
- DONE:
  - queue_done=1, spawn_valid=0. game_time keeps counting.
  - Leave DONE only on start (restart) or rst.
- game_time:
  - Increments on frame_tick in every state except IDLE.
  - Saturates at END_TS-1 and never wraps.
  - A frame_tick in the same cycle as start is ignored; game_time=0 after start.
- halt (any state other than IDLE):
  - Next cycle: FSM goes to IDLE and spawn_valid=0. This is the only case in which valid may drop without a transfer.
  - game_time, spawn_cnt and queue_done freeze.
- start while running (not IDLE): full restart exactly as from IDLE. Any pending request is dropped without a transfer.
- Simultaneous events, by priority:
  - rst highest, then halt, then start.
  - spawn_ready in the same cycle as halt: no transfer is counted.
- spawn_ready asserted while spawn_valid=0: ignored.
- Width rules:
  - All comparisons are unsigned.
  - spawn_cnt is ADDR_W+1 bits, so it reaches 2^ADDR_W without overflow.

Test Plan:
- Level 1 ROM {ts=0,type=2},{ts=5,type=1},{END}; ready tied high; start → spawn type 2 by cycle 4; type 1 accepted only after the 5th frame_tick; queue_done=1; spawn_cnt=2.
- Three entries with ts=3 on level 2; ready high; 3 frame ticks → three transfers exactly 4 cycles apart; types match ROM order.
- Backpressure: ready held low 20 cycles with valid high → spawn_type stable and spawn_cnt unchanged; raise ready → exactly one transfer, then valid drops.
- halt mid-OFFER while ready=0 → valid=0 next cycle; FSM in IDLE; game_time frozen; subsequent start with level=3 → rom_addr=0, game_time=0, level-3 entries are read.
- Full 64-entry queue with no END marker and all ts=0 → 64 transfers; spawn_cnt=64; queue_done=1; rom_addr stays 63 with no wrap.
- rst asserted during WAIT_T → all outputs at reset values next cycle; start with level=0 → remains IDLE.
